logic_unit_pipe: RTL

Parametrised, pipelined bitwise logic unit for the SPARC integer datapath, successor to the fixed 4-bit combinational inverter. It performs the SPARC logical operations (AND, ANDN, OR, ORN, XOR, XNOR, NOT, MOV) on WIDTH-bit operands through a DEPTH-stage elastic pipeline with valid/ready backpressure. It also maintains the integer condition codes (icc) for logical ops that set them. It sits between the register-read stage and writeback.

---
 rtl/logic_unit_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined SPARC bitwise logic unit with elastic valid/ready stages.
// Keeps the integer condition codes for ops that retire with set_cc.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_set_cc,
    output logic [3:0]       icc
);

    logic             vld_p [DEPTH];
    logic [WIDTH-1:0] res_p [DEPTH];
    logic             scc_p [DEPTH];
    logic             rdy   [DEPTH];
    logic [WIDTH-1:0] res_p0_d;
    logic [3:0]       icc_q;

    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] f,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (f)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~x;
            3'b100:  r = x & ~y;
            3'b101:  r = x | ~y;
            3'b110:  r = ~(x ^ y);
            default: r = y;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] logic_cc(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], ~|r, 2'b00};
    endfunction

    assign res_p0_d = logic_op(op, a, b);

    // A stage can load when it is empty or the stage after it is loading too.
    always_comb begin
        logic r;
        r = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r      = !vld_p[k] || r;
            rdy[k] = r;
        end
    end

    // Stage 0 captures the computed result; later stages are plain elastic slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_p[k] <= 1'b0;
                res_p[k] <= '0;
                scc_p[k] <= 1'b0;
            end
        end else begin
            if (rdy[0]) begin
                vld_p[0] <= in_valid;
                if (in_valid) begin
                    res_p[0] <= res_p0_d;
                    scc_p[0] <= set_cc;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    if (vld_p[k-1]) begin
                        res_p[k] <= res_p[k-1];
                        scc_p[k] <= scc_p[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icc_q <= 4'b0000;
        end else if (out_valid && out_ready && out_set_cc) begin
            icc_q <= logic_cc(result);
        end
    end

    assign in_ready   = rdy[0];
    assign out_valid  = vld_p[DEPTH-1];
    assign result     = res_p[DEPTH-1];
    assign out_set_cc = scc_p[DEPTH-1];
    assign icc        = icc_q;

endmodule
